// File: rtl/conv33_rr_scheduler.sv
// Shared 3x3 convolution engine: round-robin issue from NUM_REQ requesters into a
// 2-stage multiply / adder-tree pipeline. Define CONV33_SCHED_STATS_EN for issue/stall counters.
module conv33_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 6,
  parameter int OW      = 18,
  parameter int IDW     = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*9*DW-1:0] req_pix,
  input  logic [NUM_REQ*9*DW-1:0] req_ker,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OW-1:0]           out_data,
  output logic [IDW-1:0]          out_id
`ifdef CONV33_SCHED_STATS_EN
  ,
  output logic [31:0]             stat_issued,
  output logic [31:0]             stat_stall
`endif
);

  localparam int PW = 2 * DW;

  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [IDW-1:0]      win_id;
  logic                any_valid;
  logic                advance;
  logic                issue;
  logic [NUM_REQ-1:0]  grant;
  logic [9*DW-1:0]     win_pix, win_ker;
  logic [9*PW-1:0]     prod_d;

  logic                s1_valid_q;
  logic [9*PW-1:0]     s1_prod_q;
  logic [IDW-1:0]      s1_id_q;

  logic                out_valid_q;
  logic [OW-1:0]       out_data_q;
  logic [IDW-1:0]      out_id_q;

  // Balanced tree: four pair sums, two quad sums, one octet sum, then the ninth tap.
  function automatic logic [OW-1:0] tree_sum(input logic [9*PW-1:0] p);
    logic [OW-1:0] a0, a1, a2, a3, b0, b1, c0;
    a0 = OW'(p[0*PW +: PW]) + OW'(p[1*PW +: PW]);
    a1 = OW'(p[2*PW +: PW]) + OW'(p[3*PW +: PW]);
    a2 = OW'(p[4*PW +: PW]) + OW'(p[5*PW +: PW]);
    a3 = OW'(p[6*PW +: PW]) + OW'(p[7*PW +: PW]);
    b0 = a0 + a1;
    b1 = a2 + a3;
    c0 = b0 + b1;
    return c0 + OW'(p[8*PW +: PW]);
  endfunction

  assign advance = !out_valid_q || out_ready;

  // Round-robin search starting at ptr_q, wrapping modulo NUM_REQ.
  always_comb begin
    int idx;
    any_valid = 1'b0;
    win_id    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_valid && req_valid[idx]) begin
        any_valid = 1'b1;
        win_id    = IDW'(idx);
      end
    end
  end

  assign issue     = en && advance && any_valid;
  assign grant     = issue ? (NUM_REQ'(1) << win_id) : '0;
  assign req_ready = grant;

  always_comb begin
    ptr_d = ptr_q;
    if (issue) ptr_d = (win_id == IDW'(NUM_REQ - 1)) ? '0 : win_id + IDW'(1);
  end

  assign win_pix = req_pix[int'(win_id)*9*DW +: 9*DW];
  assign win_ker = req_ker[int'(win_id)*9*DW +: 9*DW];

  always_comb begin
    prod_d = '0;
    for (int t = 0; t < 9; t++)
      prod_d[t*PW +: PW] = PW'(win_pix[t*DW +: DW]) * PW'(win_ker[t*DW +: DW]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  // Stage 1: products of the granted window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       s1_valid_q <= 1'b0;
    else if (advance) s1_valid_q <= issue;
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      s1_prod_q <= prod_d;
      s1_id_q   <= win_id;
    end
  end

  // Stage 2: adder tree into the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
    end else if (advance) begin
      out_valid_q <= s1_valid_q;
      out_data_q  <= tree_sum(s1_prod_q);
      out_id_q    <= s1_id_q;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

`ifdef CONV33_SCHED_STATS_EN
  logic [31:0] stat_issued_q, stat_stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issued_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      if (issue)                     stat_issued_q <= stat_issued_q + 32'd1;
      if (out_valid_q && !out_ready) stat_stall_q  <= stat_stall_q + 32'd1;
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_conv33_rr_scheduler.sv
// Testbench for conv33_rr_scheduler: directed scenarios plus random traffic against a
// transaction-level model (round-robin pointer, two-slot pipeline, result queue).
module tb_conv33_rr_scheduler;

  localparam int NR = 4;
  localparam int DW = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [NR*9*DW-1:0] req_pix = '0;
  logic [NR*9*DW-1:0] req_ker = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [17:0]       out_data;
  logic [1:0]        out_id;
`ifdef CONV33_SCHED_STATS_EN
  logic [31:0]       stat_issued, stat_stall;
`endif

  conv33_rr_scheduler #(.NUM_REQ(NR), .DW(DW), .OW(18), .IDW(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_pix(req_pix), .req_ker(req_ker),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id)
`ifdef CONV33_SCHED_STATS_EN
    , .stat_issued(stat_issued), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { int data; int id; } item_t;
  item_t      m_q[$];
  int         m_ptr = 0;
  bit         m_s1v = 0, m_ov = 0;
  logic [NR-1:0] last_rdy = '0;

  function automatic int win_sum(int r);
    int s = 0;
    for (int t = 0; t < 9; t++)
      s += int'(req_pix[(r*9+t)*DW +: DW]) * int'(req_ker[(r*9+t)*DW +: DW]);
    return s;
  endfunction

  // Model evaluated every negedge; it predicts the grant and the output slot.
  always @(negedge clk) begin : monitor
    bit adv;
    int win;
    logic [NR-1:0] exp_rdy;
    item_t it;
    if (!rst_n) begin
      m_ptr = 0; m_s1v = 0; m_ov = 0; m_q.delete(); last_rdy = '0;
    end else begin
      adv = !m_ov || out_ready;
      win = -1;
      for (int i = 0; i < NR; i++)
        if (win < 0 && req_valid[(m_ptr + i) % NR]) win = (m_ptr + i) % NR;
      exp_rdy = (en && adv && win >= 0) ? NR'(1 << win) : '0;
      n_checks++;
      if (req_ready !== exp_rdy) begin
        n_fail++; $display("FAIL mon_grant: got %b expected %b at %0t", req_ready, exp_rdy, $time);
      end
      n_checks++;
      if (out_valid !== m_ov) begin
        n_fail++; $display("FAIL mon_out_valid: got %b expected %b at %0t", out_valid, m_ov, $time);
      end
      if (m_ov && m_q.size() > 0) begin
        n_checks++;
        if (out_data !== 18'(m_q[0].data) || out_id !== 2'(m_q[0].id)) begin
          n_fail++;
          $display("FAIL mon_result: got data %0d id %0d expected data %0d id %0d at %0t",
                   out_data, out_id, m_q[0].data, m_q[0].id, $time);
        end
      end
      if (adv) begin
        if (m_ov && out_ready && m_q.size() > 0) void'(m_q.pop_front());
        m_ov  = m_s1v;
        m_s1v = (exp_rdy != '0);
        if (exp_rdy != '0) begin
          it.data = win_sum(win); it.id = win;
          m_q.push_back(it);
          m_ptr = (win + 1) % NR;
        end
      end
      last_rdy = req_ready;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_tap(int r, int t, int p, int k);
    req_pix[(r*9+t)*DW +: DW] = DW'(p);
    req_ker[(r*9+t)*DW +: DW] = DW'(k);
  endtask

  task automatic set_all(int r, int p, int k);
    for (int t = 0; t < 9; t++) set_tap(r, t, p, k);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drain(int n);
    req_valid = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; req_valid = '0; out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 18'd0 || out_id !== 2'd0) begin
      n_fail++; $display("FAIL reset_outputs: got v=%b d=%0d id=%0d required 0/0/0", out_valid, out_data, out_id);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single_issue();
    en = 1'b1; out_ready = 1'b1;
    set_all(2, 63, 63);
    req_valid = 4'b0100;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL single_ready: got %b required 0100", req_ready);
    end
    tick();
    req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_latency_early: out_valid %b required 0", out_valid);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 18'd35721 || out_id !== 2'd2) begin
      n_fail++; $display("FAIL single_result: got v=%b d=%0d id=%0d required 1/35721/2", out_valid, out_data, out_id);
    end
    tick();
    req_valid = 4'b1111;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b1000) begin
      n_fail++; $display("FAIL single_ptr_next: got %b required 1000", req_ready);
    end
    tick();
    drain(4);
  endtask

  task automatic test_round_robin();
    int g[5];
    item_t outs[$];
    item_t it;
    do_reset();
    en = 1'b1; out_ready = 1'b1;
    for (int r = 0; r < NR; r++) set_all(r, r + 1, 1);
    req_valid = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c < 5) begin
        g[c] = -1;
        for (int r = 0; r < NR; r++) if (req_ready[r]) g[c] = r;
      end
      if (out_valid) begin it.data = int'(out_data); it.id = int'(out_id); outs.push_back(it); end
      tick();
      if (c == 4) req_valid = '0;
    end
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (g[c] !== (c % NR)) begin
        n_fail++; $display("FAIL rr_order[%0d]: got %0d required %0d", c, g[c], c % NR);
      end
    end
    n_checks++;
    if (outs.size() != 5) begin
      n_fail++; $display("FAIL rr_count: got %0d results required 5", outs.size());
    end else begin
      for (int c = 0; c < 5; c++) begin
        n_checks++;
        if (outs[c].data != 9 * ((c % NR) + 1) || outs[c].id != (c % NR)) begin
          n_fail++; $display("FAIL rr_result[%0d]: got %0d/id%0d required %0d/id%0d",
                             c, outs[c].data, outs[c].id, 9 * ((c % NR) + 1), c % NR);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int exp_d[3] = '{54, 225, 63};
    int exp_i[3] = '{0, 1, 2};
    item_t outs[$];
    item_t it;
    bit granted;
`ifdef CONV33_SCHED_STATS_EN
    logic [31:0] stall0;
`endif
    set_all(0, 2, 3); set_all(1, 5, 5); set_all(2, 1, 7);
    out_ready = 1'b1; en = 1'b1;
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b0100; out_ready = 1'b0;
`ifdef CONV33_SCHED_STATS_EN
    stall0 = stat_stall;
`endif
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 18'd54 || out_id !== 2'd0 || req_ready !== 4'b0000) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got v=%b d=%0d id=%0d rdy=%b required 1/54/0/0000",
                           c, out_valid, out_data, out_id, req_ready);
      end
      tick();
    end
    out_ready = 1'b1;
`ifdef CONV33_SCHED_STATS_EN
    n_checks++;
    if (stat_stall - stall0 !== 32'd5) begin
      n_fail++; $display("FAIL bp_stat_stall: got %0d required 5", stat_stall - stall0);
    end
`endif
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL bp_release_grant: got %b required 0100", req_ready);
    end
    for (int c = 0; c < 7; c++) begin
      if (c > 0) @(negedge clk);
      granted = req_ready[2];
      if (out_valid) begin it.data = int'(out_data); it.id = int'(out_id); outs.push_back(it); end
      tick();
      if (granted) req_valid = '0;
    end
    n_checks++;
    if (outs.size() != 3) begin
      n_fail++; $display("FAIL bp_count: got %0d results required 3", outs.size());
    end else begin
      for (int c = 0; c < 3; c++) begin
        n_checks++;
        if (outs[c].data != exp_d[c] || outs[c].id != exp_i[c]) begin
          n_fail++; $display("FAIL bp_result[%0d]: got %0d/id%0d required %0d/id%0d",
                             c, outs[c].data, outs[c].id, exp_d[c], exp_i[c]);
        end
      end
    end
  endtask

  task automatic test_en_gating();
    item_t outs[$];
    item_t it;
    set_all(1, 1, 2); set_all(3, 3, 3);
    en = 1'b1; out_ready = 1'b1;
    req_valid = 4'b1010;
    tick();
    req_valid = 4'b0010;
    tick();
    en = 1'b0; req_valid = 4'b1010;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_checks++;
      if (req_ready !== 4'b0000) begin
        n_fail++; $display("FAIL en_low_ready[%0d]: got %b required 0000", c, req_ready);
      end
      if (out_valid) begin it.data = int'(out_data); it.id = int'(out_id); outs.push_back(it); end
      tick();
    end
    n_checks++;
    if (outs.size() != 2 || outs[0].data != 81 || outs[0].id != 3 || outs[1].data != 18 || outs[1].id != 1) begin
      n_fail++; $display("FAIL en_drain: got %0d results (first %0d) required 81/id3 then 18/id1",
                         outs.size(), outs.size() > 0 ? outs[0].data : -1);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL en_idle_valid: got %b required 0", out_valid);
    end
    en = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b1000) begin
      n_fail++; $display("FAIL en_resume: got %b required 1000", req_ready);
    end
    tick();
    drain(4);
  endtask

  task automatic test_async_reset();
    for (int r = 0; r < NR; r++) set_all(r, 7, 9);
    en = 1'b1; out_ready = 1'b1; req_valid = 4'b1111;
    tick(); tick(); tick();
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL areset_pre: out_valid %b required 1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 18'd0 || out_id !== 2'd0) begin
      n_fail++; $display("FAIL areset_immediate: got v=%b d=%0d id=%0d required 0/0/0", out_valid, out_data, out_id);
    end
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL areset_first_grant: got %b required 0001", req_ready);
    end
    tick();
    drain(4);
  endtask

  task automatic test_mixed_taps();
    for (int t = 0; t < 9; t++) set_tap(1, t, t, 8 - t);
    en = 1'b1; out_ready = 1'b1;
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    tick();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 18'd84 || out_id !== 2'd1) begin
      n_fail++; $display("FAIL mixed_taps: got v=%b d=%0d id=%0d required 1/84/1", out_valid, out_data, out_id);
    end
    tick();
    drain(3);
  endtask

  task automatic test_random_traffic();
    int acc = 0, delivered = 0;
    for (int c = 0; c < 400; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      en        = ($urandom_range(0, 7) != 0);
      for (int r = 0; r < NR; r++) begin
        if (!(req_valid[r] && !last_rdy[r])) begin
          req_valid[r] = 1'($urandom_range(0, 1));
          for (int t = 0; t < 9; t++) set_tap(r, t, $urandom_range(0, 63), $urandom_range(0, 63));
        end
      end
      @(negedge clk);
      if (req_ready != '0) acc++;
      if (out_valid && out_ready) delivered++;
      tick();
    end
    req_valid = '0; en = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) delivered++;
      tick();
    end
    n_checks++;
    if (acc == 0 || acc != delivered) begin
      n_fail++; $display("FAIL random_conservation: accepted %0d delivered %0d", acc, delivered);
    end
  endtask

  initial begin
    test_reset();
    test_single_issue();
    test_round_robin();
    test_backpressure();
    test_en_gating();
    test_async_reset();
    test_mixed_taps();
    test_random_traffic();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
